// File: rtl/zap_wb_store_drain.sv
// Store-buffer drain: pops one FIFO entry at a time into a Wishbone B3 classic write.
// Define ZAP_WB_DRAIN_TIMEOUT_EN to add a per-write watchdog that aborts hung writes.
module zap_wb_store_drain #(
    parameter int ADDR_WDT = 32,
    parameter int DATA_WDT = 32,
    parameter int SEL_WDT  = DATA_WDT / 8,
    parameter int TIMEOUT  = 256
) (
    input  logic                                   i_clk,
    input  logic                                   i_reset_n,
    input  logic [SEL_WDT+ADDR_WDT+DATA_WDT-1:0]   i_fifo_data,
    input  logic                                   i_fifo_empty,
    output logic                                   o_fifo_ack,
    output logic                                   o_wb_cyc,
    output logic                                   o_wb_stb,
    output logic                                   o_wb_we,
    output logic [ADDR_WDT-1:0]                    o_wb_adr,
    output logic [DATA_WDT-1:0]                    o_wb_dat,
    output logic [SEL_WDT-1:0]                     o_wb_sel,
    input  logic                                   i_wb_ack,
    input  logic                                   i_wb_err,
    input  logic                                   i_err_clr,
    output logic                                   o_idle,
    output logic                                   o_err
);

    localparam int ENT_WDT = SEL_WDT + ADDR_WDT + DATA_WDT;

    localparam logic [0:0] IDLE  = 1'b0;
    localparam logic [0:0] WRITE = 1'b1;

    if ((DATA_WDT % 8) != 0) begin : g_bad_data_wdt
        $error("DATA_WDT must be a multiple of 8");
    end
    if (SEL_WDT != DATA_WDT / 8) begin : g_bad_sel_wdt
        $error("SEL_WDT is derived and must not be overridden");
    end
    if (TIMEOUT < 2) begin : g_bad_timeout
        $error("TIMEOUT must be >= 2");
    end

    logic [0:0]         state;
    logic [ENT_WDT-1:0] entry;
    logic               cyc;
    logic               resp;
    logic               abort;
    logic               done;
    logic               err_set;

    assign o_fifo_ack = (state == IDLE) & ~i_fifo_empty;
    assign o_idle     = (state == IDLE) & i_fifo_empty;

    assign o_wb_cyc = cyc;
    assign o_wb_stb = cyc;
    assign o_wb_we  = cyc;
    assign o_wb_dat = entry[DATA_WDT-1:0];
    assign o_wb_adr = entry[DATA_WDT +: ADDR_WDT];
    assign o_wb_sel = entry[ENT_WDT-1 -: SEL_WDT];

    assign resp = i_wb_ack | i_wb_err;

`ifdef ZAP_WB_DRAIN_TIMEOUT_EN
    localparam int CNT_WDT = $clog2(TIMEOUT) + 1;

    logic [CNT_WDT-1:0] cnt;

    // A slave response in the final cycle still counts as a normal completion.
    assign abort = (state == WRITE) & ~resp
                 & (cnt == CNT_WDT'(TIMEOUT - 1));

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            cnt <= '0;
        end else if (o_fifo_ack) begin
            cnt <= '0;
        end else if (state == WRITE) begin
            cnt <= cnt + 1'b1;
        end
    end
`else
    assign abort = 1'b0;
`endif

    assign done    = (state == WRITE) & (resp | abort);
    assign err_set = (state == WRITE) & (i_wb_err | abort);

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state <= IDLE;
            cyc   <= 1'b0;
            entry <= '0;
        end else if (o_fifo_ack) begin
            state <= WRITE;
            cyc   <= 1'b1;
            entry <= i_fifo_data;
        end else if (done) begin
            state <= IDLE;
            cyc   <= 1'b0;
        end
    end

    // A new error outranks a clear arriving in the same cycle.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            o_err <= 1'b0;
        end else if (err_set) begin
            o_err <= 1'b1;
        end else if (i_err_clr) begin
            o_err <= 1'b0;
        end
    end

endmodule
